seq_alu: RTL and testbench

- Parametrised, registered, multi-cycle successor to the combinational ALU.
- Keeps the add/sub/shift/compare opcode set and adds iterative unsigned multiply (shift-add) and divide (restoring).
- Operands are captured on a start/busy/done handshake, so benches and controllers no longer emulate multiply by repeated add.
- Sits between the control sequencer and the register file as the team's shared arithmetic unit.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/seq_alu_iter.sv | 72 +++++++
 rtl/seq_alu.sv | 190 +++++++++++++++++++
 tb/tb_seq_alu.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and
// the iterative datapath mode.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_SHL = 4'b0010;
  localparam logic [OP_W-1:0] OP_SHR = 4'b0011;
  localparam logic [OP_W-1:0] OP_EQ  = 4'b0100;
  localparam logic [OP_W-1:0] OP_GT  = 4'b0101;
  localparam logic [OP_W-1:0] OP_LT  = 4'b0110;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0111;
  localparam logic [OP_W-1:0] OP_DIV = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_e;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: shift-add multiply and restoring divide sharing a
// single N+1-bit adder. Exposes the post-step hi/lo values.
import alu_pkg::*;

module seq_alu_iter #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  iter_mode_e mode_i,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] hi_nxt_o,
  output logic [N-1:0] lo_nxt_o
);

  iter_mode_e   mode_q;
  logic [N-1:0] hi_q, lo_q, opnd_q;
  logic [N-1:0] hi_d, lo_d;
  logic [N:0]   add_x_s, add_y_s, sum_s;
  logic         cin_s;

  // mul: hi accumulates, lo holds the multiplier shifting out LSB first.
  // div: {hi,lo} shifts left; sum_s[N] set means the trial subtract borrowed.
  always_comb begin
    if (mode_q == MODE_DIV) begin
      add_x_s = {hi_q, lo_q[N-1]};
      add_y_s = ~{1'b0, opnd_q};
      cin_s   = 1'b1;
    end else begin
      add_x_s = {1'b0, hi_q};
      add_y_s = lo_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}};
      cin_s   = 1'b0;
    end
    sum_s = add_x_s + add_y_s + {{N{1'b0}}, cin_s};
    if (mode_q == MODE_DIV) begin
      if (sum_s[N]) begin
        hi_d = add_x_s[N-1:0];
        lo_d = {lo_q[N-2:0], 1'b0};
      end else begin
        hi_d = sum_s[N-1:0];
        lo_d = {lo_q[N-2:0], 1'b1};
      end
    end else begin
      hi_d = sum_s[N:1];
      lo_d = {sum_s[0], lo_q[N-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_MUL;
      hi_q   <= {N{1'b0}};
      lo_q   <= {N{1'b0}};
      opnd_q <= {N{1'b0}};
    end else if (load_i) begin
      mode_q <= mode_i;
      hi_q   <= {N{1'b0}};
      lo_q   <= (mode_i == MODE_DIV) ? a_i : b_i;
      opnd_q <= (mode_i == MODE_DIV) ? b_i : a_i;
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_nxt_o = hi_d;
  assign lo_nxt_o = lo_d;

endmodule

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU: single-cycle add/sub/shift/compare plus
// iterative unsigned multiply and divide behind a start/busy/done handshake.
import alu_pkg::*;

module seq_alu #(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    o,
  output logic [N-1:0]    o_hi,
  output logic            of,
  output logic            uf,
  output logic            cmp,
  output logic            zero,
  output logic            err
);

  localparam logic [N:0] N_VAL = (N+1)'(N);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [N-1:0]    o_q, o_d, o_hi_q, o_hi_d;
  logic            of_q, of_d, uf_q, uf_d, cmp_q, cmp_d, zero_q, zero_d, err_q, err_d;

  logic            load_s, step_s, big_shift_s;
  iter_mode_e      mode_s;
  logic [N:0]      add_s;
  logic [N-1:0]    shl_s, shr_s, hi_nxt_s, lo_nxt_s;

  seq_alu_iter #(.N(N)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode_i   (mode_s),
    .load_i   (load_s),
    .step_i   (step_s),
    .a_i      (a),
    .b_i      (b),
    .hi_nxt_o (hi_nxt_s),
    .lo_nxt_o (lo_nxt_s)
  );

  assign add_s       = {1'b0, a} + {1'b0, b};
  assign big_shift_s = ({1'b0, b} >= N_VAL);
  assign shl_s       = big_shift_s ? {N{1'b0}} : (a << b);
  assign shr_s       = big_shift_s ? {N{1'b0}} : (a >> b);
  assign mode_s      = (op == OP_DIV) ? MODE_DIV : MODE_MUL;

  // FSM next state, counter and result/flag registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    o_d     = o_q;
    o_hi_d  = o_hi_q;
    of_d    = of_q;
    uf_d    = uf_q;
    cmp_d   = cmp_q;
    zero_d  = zero_q;
    err_d   = err_q;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          o_d     = {N{1'b0}};
          o_hi_d  = {N{1'b0}};
          of_d    = 1'b0;
          uf_d    = 1'b0;
          cmp_d   = 1'b0;
          zero_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
          case (op)
            OP_ADD: begin
              o_d    = add_s[N-1:0];
              of_d   = add_s[N];
              zero_d = (add_s[N-1:0] == {N{1'b0}});
            end
            OP_SUB: begin
              o_d    = a - b;
              uf_d   = (a < b);
              zero_d = (a == b);
            end
            OP_SHL: begin
              o_d    = shl_s;
              zero_d = (shl_s == {N{1'b0}});
            end
            OP_SHR: begin
              o_d    = shr_s;
              zero_d = (shr_s == {N{1'b0}});
            end
            OP_EQ: cmp_d = (a == b);
            OP_GT: cmp_d = (a > b);
            OP_LT: cmp_d = (a < b);
            OP_MUL, OP_DIV: begin
              if ((op == OP_DIV) && (b == {N{1'b0}})) begin
                err_d  = 1'b1;
                o_d    = {N{1'b1}};
                o_hi_d = a;
              end else begin
                load_s  = 1'b1;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                cnt_d   = {CW{1'b0}};
                state_d = ST_RUN;
              end
            end
            default: err_d = 1'b1;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
          o_d     = lo_nxt_s;
          o_hi_d  = hi_nxt_s;
          zero_d  = (lo_nxt_s == {N{1'b0}});
          of_d    = (op_q == OP_MUL) && (hi_nxt_s != {N{1'b0}});
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      op_q    <= {OP_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      o_q     <= {N{1'b0}};
      o_hi_q  <= {N{1'b0}};
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
      cmp_q   <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      o_q     <= o_d;
      o_hi_q  <= o_hi_d;
      of_q    <= of_d;
      uf_q    <= uf_d;
      cmp_q   <= cmp_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign o    = o_q;
  assign o_hi = o_hi_q;
  assign of   = of_q;
  assign uf   = uf_q;
  assign cmp  = cmp_q;
  assign zero = zero_q;
  assign err  = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu (N=8): expected results are queued
// at issue and compared when done pulses.
import alu_pkg::*;

module tb_seq_alu;

  logic       clk, rst_n, start;
  logic [3:0] op;
  logic [7:0] a, b;
  logic       busy, done, of, uf, cmp, zero, err;
  logic [7:0] o, o_hi;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] o;
    logic [7:0] o_hi;
    logic       of, uf, cmp, zero, err;
    int         lat;
  } exp_t;

  exp_t sb[$];

  seq_alu #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .o(o), .o_hi(o_hi),
    .of(of), .uf(uf), .cmp(cmp), .zero(zero), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op_v, input logic [7:0] a_v, input logic [7:0] b_v);
    exp_t e;
    int   r;
    e.o = 8'd0; e.o_hi = 8'd0;
    e.of = 1'b0; e.uf = 1'b0; e.cmp = 1'b0; e.zero = 1'b0; e.err = 1'b0;
    e.lat = 1;
    case (op_v)
      4'd0: begin r = int'(a_v) + int'(b_v); e.o = 8'(r % 256); e.of = (r > 255); e.zero = (e.o == 8'd0); end
      4'd1: begin r = int'(a_v) - int'(b_v) + 256; e.o = 8'(r % 256); e.uf = (int'(a_v) < int'(b_v)); e.zero = (e.o == 8'd0); end
      4'd2: begin r = (int'(b_v) >= 8) ? 0 : ((int'(a_v) * (2 ** int'(b_v))) % 256); e.o = 8'(r); e.zero = (r == 0); end
      4'd3: begin r = (int'(b_v) >= 8) ? 0 : (int'(a_v) / (2 ** int'(b_v))); e.o = 8'(r); e.zero = (r == 0); end
      4'd4: e.cmp = (int'(a_v) == int'(b_v));
      4'd5: e.cmp = (int'(a_v) > int'(b_v));
      4'd6: e.cmp = (int'(a_v) < int'(b_v));
      4'd7: begin
        r = int'(a_v) * int'(b_v);
        e.o = 8'(r % 256); e.o_hi = 8'(r / 256);
        e.of = (r > 255); e.zero = (e.o == 8'd0); e.lat = 9;
      end
      4'd8: begin
        if (b_v == 8'd0) begin
          e.err = 1'b1; e.o = 8'd255; e.o_hi = a_v;
        end else begin
          e.o = 8'(int'(a_v) / int'(b_v)); e.o_hi = 8'(int'(a_v) % int'(b_v));
          e.zero = (e.o == 8'd0); e.lat = 9;
        end
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Issue one op in an idle cycle; optionally pulse a conflicting start at cycle inj.
  task automatic run_op(input string tag, input logic [3:0] op_v, input logic [7:0] a_v,
                        input logic [7:0] b_v, input int inj);
    exp_t e;
    int   cyc;
    bit   got;
    sb.push_back(model(op_v, a_v, b_v));
    op = op_v; a = a_v; b = b_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc <= 40) begin
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        check({tag, ":busy"}, 32'(busy), 32'd1);
        if (cyc == inj) begin
          start = 1'b1; op = OP_ADD; a = 8'd1; b = 8'd1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, ":done"}, 32'(done), 32'd1);
    e = sb.pop_front();
    check({tag, ":lat"}, 32'(cyc), 32'(e.lat));
    check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ":o"}, 32'(o), 32'(e.o));
    check({tag, ":o_hi"}, 32'(o_hi), 32'(e.o_hi));
    check({tag, ":flags"}, 32'({of, uf, cmp, zero, err}), 32'({e.of, e.uf, e.cmp, e.zero, e.err}));
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, 32'(done), 32'd0);
    check({tag, ":o_hold"}, 32'(o), 32'(e.o));
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; op = 4'd0; a = 8'd0; b = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:outs", 32'({o, o_hi, of, uf, cmp, zero, err}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_200_100", OP_ADD, 8'd200, 8'd100, 0);
    run_op("sub_3_5",     OP_SUB, 8'd3,   8'd5,   0);
    run_op("mul_15_17",   OP_MUL, 8'd15,  8'd17,  0);
    run_op("mul_200_3",   OP_MUL, 8'd200, 8'd3,   0);
    run_op("div_100_7",   OP_DIV, 8'd100, 8'd7,   0);
    run_op("div_100_0",   OP_DIV, 8'd100, 8'd0,   0);
    run_op("gt_5_3",      OP_GT,  8'd5,   8'd3,   0);
    run_op("eq_9_9",      OP_EQ,  8'd9,   8'd9,   0);
    run_op("shl_1_9",     OP_SHL, 8'd1,   8'd9,   0);
    run_op("illegal",     4'b1010, 8'd12, 8'd34,  0);
    run_op("shr_128_3",   OP_SHR, 8'd128, 8'd3,   0);
    run_op("shl_3_7",     OP_SHL, 8'd3,   8'd7,   0);
    run_op("lt_3_5",      OP_LT,  8'd3,   8'd5,   0);
    run_op("lt_5_5",      OP_LT,  8'd5,   8'd5,   0);
    run_op("mul_0_77",    OP_MUL, 8'd0,   8'd77,  0);
    run_op("mul_255_255", OP_MUL, 8'd255, 8'd255, 0);
    run_op("div_255_1",   OP_DIV, 8'd255, 8'd1,   0);
    run_op("div_5_9",     OP_DIV, 8'd5,   8'd9,   0);
    run_op("add_255_1",   OP_ADD, 8'd255, 8'd1,   0);
    run_op("sub_7_7",     OP_SUB, 8'd7,   8'd7,   0);
    run_op("mul_inject",  OP_MUL, 8'd15,  8'd17,  3);

    // Reset in cycle 4 of a multiply aborts it without a done pulse
    op = OP_MUL; a = 8'd200; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort:busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort:busy", 32'(busy), 32'd0);
    check("abort:outs", 32'({done, o, o_hi, of, uf, cmp, zero, err}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check("abort:no_done", 32'(seen), 32'd0);

    run_op("post_reset_add", OP_ADD, 8'd1, 8'd2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
